// File: rtl/wb_mul_seq.sv
// Wishbone slave wrapping an iterative shift-add multiplier (WIDTH x WIDTH -> 64-bit result)
// with signed/unsigned mode, busy/done status and a maskable completion interrupt.
module wb_mul_seq #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [5:0] OFF_A    = 6'h00;
    localparam logic [5:0] OFF_B    = 6'h01;
    localparam logic [5:0] OFF_CTRL = 6'h02;
    localparam logic [5:0] OFF_STAT = 6'h03;
    localparam logic [5:0] OFF_PLO  = 6'h04;
    localparam logic [5:0] OFF_PHI  = 6'h05;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_irq_en;
    logic             r_done;
    logic [63:0]      r_p;

    logic [WIDTH-1:0] r_mcand;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_op_signed;

    logic             r_ack;
    logic [31:0]      r_dat;

    logic             w_hit;
    logic             w_req;
    logic             w_wr;
    logic             w_rd;
    logic [5:0]       w_off;
    logic             w_a_wr;
    logic             w_b_wr;
    logic             w_ctrl_wr;
    logic             w_start;
    logic             w_done_clr;
    logic             w_busy;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [31:0]      w_rdata;
    logic             w_unused;

    function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                    input logic [31:0]      din,
                                                    input logic [3:0]       sel);
        for (int i = 0; i < WIDTH; i++) begin
            lane_merge[i] = sel[i/8] ? din[i] : old_v[i];
        end
    endfunction

    // A signed -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        magnitude = (sgn && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [63:0] finish_product(input logic [PW-1:0] p,
                                                   input logic          neg,
                                                   input logic          sgn);
        logic [PW-1:0] v;
        v = neg ? ((~p) + PW'(1)) : p;
        finish_product = sgn ? 64'($signed(v)) : 64'(v);
    endfunction

    assign w_hit      = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign w_req      = wbs_cyc_i & wbs_stb_i & ~r_ack & w_hit;
    assign w_wr       = w_req & wbs_we_i;
    assign w_rd       = w_req & ~wbs_we_i;
    assign w_off      = wbs_adr_i[7:2];
    assign w_a_wr     = w_wr && (w_off == OFF_A);
    assign w_b_wr     = w_wr && (w_off == OFF_B);
    assign w_ctrl_wr  = w_wr && (w_off == OFF_CTRL) && wbs_sel_i[0];
    assign w_start    = w_ctrl_wr && wbs_dat_i[0] && (r_state == S_IDLE);
    assign w_done_clr = w_wr && (w_off == OFF_STAT) && wbs_sel_i[0] && wbs_dat_i[1];
    assign w_busy     = (r_state != S_IDLE);
    assign w_unused   = ^wbs_adr_i[1:0];

    // Accumulator upper half gains the multiplicand when the multiplier LSB (acc[0]) is set.
    assign w_addend = r_acc[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc[PW-1:WIDTH]} + {1'b0, w_addend};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_p         <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_op_signed <= 1'b0;
        end else begin
            if (w_a_wr) r_a <= lane_merge(r_a, wbs_dat_i, wbs_sel_i);
            if (w_b_wr) r_b <= lane_merge(r_b, wbs_dat_i, wbs_sel_i);
            if (w_ctrl_wr) begin
                r_signed <= wbs_dat_i[1];
                r_irq_en <= wbs_dat_i[2];
            end

            if (w_start) begin
                r_mcand     <= magnitude(r_a, wbs_dat_i[1]);
                r_acc       <= {{WIDTH{1'b0}}, magnitude(r_b, wbs_dat_i[1])};
                r_cnt       <= '0;
                r_op_signed <= wbs_dat_i[1];
                r_neg       <= wbs_dat_i[1] & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            end else if (r_state == S_RUN) begin
                r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                r_cnt <= r_cnt + CW'(1);
            end

            if (r_state == S_FIX) begin
                r_p <= finish_product(r_acc, r_neg, r_op_signed);
            end

            // Completion wins over a same-edge write-1-to-clear.
            if (r_state == S_FIX) begin
                r_done <= 1'b1;
            end else if (w_start || w_done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_A:    w_rdata = 32'(r_a);
            OFF_B:    w_rdata = 32'(r_b);
            OFF_CTRL: w_rdata = {29'b0, r_irq_en, r_signed, 1'b0};
            OFF_STAT: w_rdata = {30'b0, r_done, w_busy};
            OFF_PLO:  w_rdata = r_p[31:0];
            OFF_PHI:  w_rdata = r_p[63:32];
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : '0;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq       = {2'b00, r_done & r_irq_en};

endmodule

// File: tb/tb_wb_mul_seq.sv
// Bench for wb_mul_seq: a 32-bit and an 8-bit instance share one Wishbone bus at different bases;
// expected products come from a behavioural model through a queue scoreboard.
module tb_wb_mul_seq;

    localparam logic [31:0] BASE32 = 32'h3000_0000;
    localparam logic [31:0] BASE8  = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack32, ack8;
    logic [31:0] dat32, dat8;
    logic [2:0]  irq32, irq8;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int ack_cyc = 0;
    int rise32 = -1;
    int rise8 = -1;
    logic prev32 = 1'b0;
    logic prev8 = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    wb_mul_seq #(.WIDTH(32), .BASE_ADR(BASE32)) dut32 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack32),
        .wbs_dat_o(dat32), .irq(irq32)
    );

    wb_mul_seq #(.WIDTH(8), .BASE_ADR(BASE8)) dut8 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack8),
        .wbs_dat_o(dat8), .irq(irq8)
    );

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (irq32[0] && !prev32) rise32 = cyc_cnt;
        prev32 = irq32[0];
        if (irq8[0] && !prev8) rise8 = cyc_cnt;
        prev8 = irq8[0];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn, input int w);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (w == 8) begin
            ua = {56'b0, a[7:0]};
            ub = {56'b0, b[7:0]};
            sa = longint'($signed(a[7:0]));
            sb = longint'($signed(b[7:0]));
        end else begin
            ua = {32'b0, a};
            ub = {32'b0, b};
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        if (sgn) model = 64'(sa * sb);
        else     model = ua * ub;
    endfunction

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdat);
        bit got;
        got = 0;
        rdat = '0;
        @(posedge clk); #1;
        adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        for (int n = 0; n < 16 && !got; n++) begin
            @(posedge clk); #1;
            if (ack32 | ack8) begin
                got = 1;
                rdat = dat32 | dat8;
                ack_cyc = cyc_cnt;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL bus_timeout adr=%h: no ack seen, required ack within 16 cycles", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(a, 1'b1, d, s, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        xfer(a, 1'b0, 32'h0, 4'hF, d);
    endtask

    task automatic launch(input logic [31:0] base, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ctrl, input int w);
        wr(base + 32'h0, a, 4'hF);
        wr(base + 32'h4, b, 4'hF);
        exp_q.push_back(model(a, b, ctrl[1], w));
        wr(base + 32'h8, ctrl, 4'hF);
    endtask

    task automatic wait_done(input logic [31:0] base, output logic [63:0] p);
        logic [31:0] st, lo, hi;
        bit done;
        done = 0;
        for (int n = 0; n < 60 && !done; n++) begin
            rd(base + 32'hC, st);
            if (st[1]) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout base=%h: DONE never set", base);
        end
        rd(base + 32'h10, lo);
        rd(base + 32'h14, hi);
        p = {hi, lo};
    endtask

    task automatic wait_irq(input bit use8);
        for (int n = 0; n < 60; n++) begin
            if ((use8 ? rise8 : rise32) >= 0) break;
            @(posedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ack32 !== 1'b0 || dat32 !== 32'h0 || irq32 !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h irq=%b, required 0/0/000", ack32, dat32, irq32);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd(BASE32 + 32'(4 * i), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h, required 00000000", i, v);
            end
        end
    endtask

    task automatic test_unsigned;
        logic [63:0] p, e;
        logic [31:0] st;
        launch(BASE32, 32'd7, 32'd6, 32'h1, 32);
        wait_done(BASE32, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e || p !== 64'h2A) begin
            errors++;
            $display("FAIL unsigned_7x6: got %h, required %h", p, e);
        end
        rd(BASE32 + 32'hC, st);
        checks++;
        if (st !== 32'h2) begin
            errors++;
            $display("FAIL unsigned_status: got %h, required 00000002", st);
        end
        launch(BASE32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32);
        wait_done(BASE32, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e || p !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL unsigned_max: got %h, required %h", p, e);
        end
    endtask

    task automatic test_signed;
        logic [63:0] p, e;
        launch(BASE32, 32'hFFFF_FFFD, 32'd5, 32'h3, 32);
        wait_done(BASE32, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e || p !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            errors++;
            $display("FAIL signed_m3x5: got %h, required %h", p, e);
        end
        launch(BASE32, 32'h8000_0000, 32'h8000_0000, 32'h3, 32);
        wait_done(BASE32, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e || p !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL signed_minxmin: got %h, required %h", p, e);
        end
    endtask

    task automatic test_irq;
        logic [63:0] p, e;
        logic [31:0] st;
        int start_cyc;
        rise32 = -1;
        launch(BASE32, 32'd3, 32'd4, 32'h5, 32);
        start_cyc = ack_cyc;
        wait_irq(1'b0);
        checks++;
        if (rise32 - start_cyc !== 33) begin
            errors++;
            $display("FAIL irq_latency: got %0d cycles, required 33", rise32 - start_cyc);
        end
        checks++;
        if (irq32 !== 3'b001) begin
            errors++;
            $display("FAIL irq_level: got %b, required 001", irq32);
        end
        wait_done(BASE32, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e) begin
            errors++;
            $display("FAIL irq_product: got %h, required %h", p, e);
        end
        wr(BASE32 + 32'hC, 32'h2, 4'hF);
        checks++;
        if (irq32 !== 3'b000) begin
            errors++;
            $display("FAIL irq_clear: got %b, required 000", irq32);
        end
        rd(BASE32 + 32'hC, st);
        checks++;
        if (st !== 32'h0) begin
            errors++;
            $display("FAIL irq_status_cleared: got %h, required 00000000", st);
        end
    endtask

    task automatic test_busy_conflicts;
        logic [63:0] p, e;
        logic [31:0] st, lo, av;
        int start_cyc;
        rise32 = -1;
        launch(BASE32, 32'd10, 32'd11, 32'h5, 32);
        start_cyc = ack_cyc;
        wr(BASE32 + 32'h0, 32'h1234, 4'hF);
        rd(BASE32 + 32'hC, st);
        checks++;
        if (st !== 32'h1) begin
            errors++;
            $display("FAIL busy_status: got %h, required 00000001", st);
        end
        rd(BASE32 + 32'h10, lo);
        checks++;
        if (lo !== 32'd12) begin
            errors++;
            $display("FAIL busy_p_hold: got %h, required 0000000c", lo);
        end
        wr(BASE32 + 32'h8, 32'h5, 4'hF);
        wait_irq(1'b0);
        checks++;
        if (rise32 - start_cyc !== 33) begin
            errors++;
            $display("FAIL busy_restart_latency: got %0d cycles, required 33", rise32 - start_cyc);
        end
        wait_done(BASE32, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e || p !== 64'd110) begin
            errors++;
            $display("FAIL busy_product: got %h, required %h", p, e);
        end
        rd(BASE32 + 32'h0, av);
        checks++;
        if (av !== 32'h1234) begin
            errors++;
            $display("FAIL busy_a_write: got %h, required 00001234", av);
        end
        wr(BASE32 + 32'hC, 32'h2, 4'hF);
    endtask

    task automatic test_done_conflict;
        logic [63:0] p, e;
        logic [31:0] st;
        launch(BASE32, 32'd2, 32'd3, 32'h1, 32);
        repeat (31) @(posedge clk);
        wr(BASE32 + 32'hC, 32'h2, 4'hF);
        rd(BASE32 + 32'hC, st);
        checks++;
        if (st !== 32'h2) begin
            errors++;
            $display("FAIL done_clear_conflict: got %h, required 00000002", st);
        end
        wait_done(BASE32, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e) begin
            errors++;
            $display("FAIL conflict_product: got %h, required %h", p, e);
        end
        wr(BASE32 + 32'hC, 32'h2, 4'hF);
        rd(BASE32 + 32'hC, st);
        checks++;
        if (st !== 32'h0) begin
            errors++;
            $display("FAIL done_clear: got %h, required 00000000", st);
        end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] st, lo, hi;
        logic [63:0] dropped;
        rise32 = -1;
        launch(BASE32, 32'd5, 32'd5, 32'h5, 32);
        dropped = exp_q.pop_front();
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (irq32 !== 3'b000) begin
            errors++;
            $display("FAIL midrun_irq: got %b, required 000 (dropped %h)", irq32, dropped);
        end
        rd(BASE32 + 32'hC, st);
        rd(BASE32 + 32'h10, lo);
        rd(BASE32 + 32'h14, hi);
        checks++;
        if (st !== 32'h0 || lo !== 32'h0 || hi !== 32'h0) begin
            errors++;
            $display("FAIL midrun_regs: status=%h p=%h%h, required all 0", st, hi, lo);
        end
        repeat (45) @(posedge clk);
        rd(BASE32 + 32'hC, st);
        checks++;
        if (rise32 !== -1 || st !== 32'h0) begin
            errors++;
            $display("FAIL midrun_no_completion: irq_rise=%0d status=%h, required -1/0", rise32, st);
        end
    endtask

    task automatic test_width8;
        logic [63:0] p, e;
        logic [31:0] v;
        int start_cyc;
        wr(BASE8 + 32'h0, 32'h1FF, 4'hF);
        rd(BASE8 + 32'h0, v);
        checks++;
        if (v !== 32'hFF) begin
            errors++;
            $display("FAIL w8_a_trunc: got %h, required 000000ff", v);
        end
        rise8 = -1;
        launch(BASE8, 32'h80, 32'h02, 32'h7, 8);
        start_cyc = ack_cyc;
        wait_irq(1'b1);
        checks++;
        if (rise8 - start_cyc !== 9) begin
            errors++;
            $display("FAIL w8_latency: got %0d cycles, required 9", rise8 - start_cyc);
        end
        wait_done(BASE8, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e || p !== 64'hFFFF_FFFF_FFFF_FF00) begin
            errors++;
            $display("FAIL w8_signed: got %h, required %h", p, e);
        end
        wr(BASE8 + 32'hC, 32'h2, 4'hF);
        launch(BASE8, 32'hFF, 32'hFF, 32'h1, 8);
        wait_done(BASE8, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== e) begin
            errors++;
            $display("FAIL w8_unsigned: got %h, required %h", p, e);
        end
    endtask

    task automatic test_lanes;
        logic [31:0] v;
        wr(BASE32 + 32'h0, 32'hAABB_CCDD, 4'hF);
        wr(BASE32 + 32'h0, 32'h1122_3344, 4'b0101);
        rd(BASE32 + 32'h0, v);
        checks++;
        if (v !== 32'hAA22_CC44) begin
            errors++;
            $display("FAIL lanes_a: got %h, required aa22cc44", v);
        end
        wr(BASE32 + 32'h8, 32'h6, 4'h2);
        rd(BASE32 + 32'h8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_sel0_ignored: got %h, required 00000000", v);
        end
        wr(BASE32 + 32'h8, 32'h6, 4'h1);
        rd(BASE32 + 32'h8, v);
        checks++;
        if (v !== 32'h6) begin
            errors++;
            $display("FAIL ctrl_readback: got %h, required 00000006", v);
        end
        wr(BASE32 + 32'h8, 32'h0, 4'h1);
        wr(BASE32 + 32'h20, 32'hFFFF_FFFF, 4'hF);
        rd(BASE32 + 32'h20, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h, required 00000000", v);
        end
    endtask

    task automatic test_window;
        int acks;
        bit exp_ack;
        acks = 0;
        @(posedge clk); #1;
        adr = BASE32; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            exp_ack = (n % 2 == 0);
            if (ack32) acks++;
            checks++;
            if (ack32 !== exp_ack || dat32 !== (exp_ack ? 32'hAA22_CC44 : 32'h0)) begin
                errors++;
                $display("FAIL held_req cycle %0d: ack=%b dat=%h, required ack=%b", n, ack32, dat32, exp_ack);
            end
        end
        checks++;
        if (acks !== 4) begin
            errors++;
            $display("FAIL held_req_count: got %0d acks, required 4", acks);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        acks = 0;
        adr = 32'h3000_0200; cyc = 1'b1; stb = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack32 | ack8) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL out_of_window: got %0d acks, required 0", acks);
        end
    endtask

    task automatic test_random;
        logic [63:0] p, e;
        logic [31:0] a, b;
        bit s;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 0) ? 32'h0 : $urandom;
            s = 1'($urandom_range(0, 1));
            launch(BASE32, a, b, {30'b0, s, 1'b1}, 32);
            wait_done(BASE32, p);
            e = exp_q.pop_front();
            checks++;
            if (p !== e) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h s=%0d: got %h, required %h", i, a, b, s, p, e);
            end
            wr(BASE32 + 32'hC, 32'h2, 4'hF);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_irq();
        test_busy_conflicts();
        test_done_conflict();
        test_reset_midrun();
        test_width8();
        test_lanes();
        test_window();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_mul_seq.md
# wb_mul_seq

Parametrised sequential Wishbone multiplier peripheral for the user project area. It is the successor to the fixed 32-bit multiplier slave, with these additions:
- configurable operand width;
- signed or unsigned mode;
- an iterative shift-add datapath with busy/done status;
- a maskable completion interrupt.

It connects directly to the management SoC Wishbone slave port and to user_irq in user_project_wrapper.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; legal values 8, 16, 32.
- BASE_ADR, 32'h3000_0000, window base; the window spans 256 bytes.

Ports:
- wb_clk_i  input  1  sole clock; all logic on its rising edge.
- wb_rst_ni  input  1  reset, synchronous, active-low.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte lane selects.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  acknowledge, registered.
- wbs_dat_o  output  32  read data, registered.
- irq  output  3  irq[0] is the completion interrupt; irq[2:1] are tied 0.

## Operation
- Address decode: the block is selected when wbs_adr_i[31:8] == BASE_ADR[31:8]. Outside this window the block never acks. The register offset is wbs_adr_i[7:2].
- Register map (offsets in bytes):
  - 0x00 A: operand, WIDTH bits, R/W. Write bits ≥ WIDTH are ignored; those bits read 0.
  - 0x04 B: same as A.
  - 0x08 CTRL: bit0 START (write-1 pulse, reads 0), bit1 SIGNED, bit2 IRQ_EN.
  - 0x0C STATUS: bit0 BUSY (RO), bit1 DONE (sticky; write 1 to clear).
  - 0x10 P_LO: result bits [31:0], RO.
  - 0x14 P_HI: result bits [63:32], RO.
  - Any other offset inside the window: acked, reads 0, writes ignored.
- Byte lanes: A and B honour wbs_sel_i per byte. CTRL and STATUS writes require wbs_sel_i[0]=1.
- START behaviour:
  - START while IDLE: latches A, B and SIGNED into internal copies, clears DONE, and enters RUN.
  - START while BUSY: ignored, but the transaction is still acked.
- Writes to A, B or CTRL during RUN update the registers but do not affect the running operation.
- FSM:
  - IDLE: on START → RUN, with iteration counter = 0.
  - RUN: 1 shift-add step per cycle on operand magnitudes. In SIGNED mode, |−2^(WIDTH−1)| = 2^(WIDTH−1), which fits in WIDTH unsigned bits. After WIDTH steps → FIX.
  - FIX: negate the 2·WIDTH-bit product if SIGNED and the operand signs differ. Extend the result to 64 bits: sign-extend in SIGNED mode, zero-extend otherwise. Load P_HI:P_LO, set DONE → IDLE.
- P_LO/P_HI change only in FIX and hold the previous result during RUN.
- irq[0] = DONE & IRQ_EN, as a level. It clears when DONE is cleared or IRQ_EN is 0.

## Timing
- Wishbone handshake:
  - A request is sampled at edge k when cyc & stb & !ack.
  - wbs_ack_o is high for exactly the one cycle following edge k, then low for at least one cycle. A held request therefore acks every other cycle.
  - Write side effects occur at edge k.
  - Read data is valid in the ack cycle and is 0 whenever ack is low.
- Multiply latency (START sampled at edge k):
  - BUSY=1 from edge k.
  - RUN occupies edges k+1 through k+WIDTH.
  - FIX occurs at edge k+WIDTH+1; BUSY=0, DONE=1 and P are valid after that edge.
  - Total: WIDTH+1 cycles.
- Same-edge conflict: a write-1 to DONE at the FIX edge loses, so DONE remains 1.
- Reset (wb_rst_ni=0 at a rising edge), including mid-RUN:
  - FSM returns to IDLE.
  - A, B, CTRL, STATUS, P_LO, P_HI are cleared to 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=3'b000.
  - An operation in progress is abandoned and produces no result.

## Test plan
- Unsigned, WIDTH=32: A=7, B=6, START=1 → after 33 cycles STATUS=0x2, P_LO=0x2A, P_HI=0.
- Unsigned max: A=B=0xFFFFFFFF → P_HI=0xFFFFFFFE, P_LO=0x00000001.
- Signed: A=0xFFFFFFFD (−3), B=5, CTRL=0x3 → P_LO=0xFFFFFFF1, P_HI=0xFFFFFFFF. Separately, A=B=0x80000000 signed → P_HI=0x40000000, P_LO=0.
- Interrupt and conflicts:
  - CTRL=0x5 → irq=3'b001 at DONE.
  - STATUS write 0x2 → irq=0.
  - START during BUSY → acked, result unchanged, and latency is not restarted.
  - A write during RUN does not alter P.
- Reset mid-RUN after cycle 10: drive wb_rst_ni=0 for 1 cycle → BUSY=0, DONE=0, P=0, irq=0, and no later completion occurs.
- WIDTH=8 build: A=0x80, B=0x02, SIGNED → completes in 9 cycles with P_LO=0xFFFFFF00, P_HI=0xFFFFFFFF. A read of A after writing 0x1FF returns 0xFF.
